// File: rtl/urv_pipe_ctrl.sv
// Pipeline stall/kill controller: branch shadow kills, trap flush with fetch-hold window.
// Optional performance counters are enabled by defining URV_PIPE_PERF_EN.
module urv_pipe_ctrl #(
    parameter int g_num_stages   = 4,
    parameter int g_branch_stage = 2,
    parameter int g_flush_hold   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [g_num_stages-1:0] stall_req_i,
    input  logic                    bra_i,
    input  logic                    trap_i,
    output logic [g_num_stages-1:0] stall_o,
    output logic [g_num_stages-1:0] kill_o,
    output logic                    busy_o,
    output logic [31:0]             perf_stall_o,
    output logic [31:0]             perf_flush_o
);

    localparam int N    = g_num_stages;
    localparam int B    = g_branch_stage;
    localparam int SH_W = $clog2(B + 1);

    logic [SH_W-1:0]  shCnt_q;
    logic [SH_W-1:0]  shCnt_d;
    logic [3:0]       holdCnt_q;
    logic [3:0]       holdCnt_d;
    logic [N-1:0]     stallVec;
    logic [N-1:0]     killVec;
    logic             braAccept;
    logic             reqAcc;

    assign busy_o = (holdCnt_q != 4'd0);

    // A stage stalls whenever it or any later stage asks to; writeback never stalls.
    always_comb begin
        stallVec      = '0;
        reqAcc        = stall_req_i[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            reqAcc      = reqAcc | stall_req_i[i];
            stallVec[i] = reqAcc;
        end
        stallVec[0]   = stallVec[0] | busy_o;
    end

    assign stall_o   = stallVec;
    assign braAccept = bra_i & ~stallVec[B] & ~trap_i;

    // Shadow pattern: with sh_cnt = k, the k youngest-relative slots up to stage B still hold wrong-path work.
    always_comb begin
        killVec = '0;
        if (trap_i) begin
            killVec = '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((i < B) && braAccept) begin
                    killVec[i] = 1'b1;
                end
                if ((i <= B) && (int'(shCnt_q) >= (B - i + 1))) begin
                    killVec[i] = 1'b1;
                end
            end
        end
    end

    assign kill_o = killVec;

    always_comb begin
        shCnt_d = shCnt_q;
        if (trap_i) begin
            shCnt_d = '0;
        end else if (braAccept) begin
            shCnt_d = SH_W'(B);
        end else if ((shCnt_q != '0) && !stallVec[B]) begin
            shCnt_d = shCnt_q - SH_W'(1);
        end
    end

    always_comb begin
        holdCnt_d = holdCnt_q;
        if (trap_i) begin
            holdCnt_d = 4'(g_flush_hold);
        end else if (holdCnt_q != 4'd0) begin
            holdCnt_d = holdCnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shCnt_q   <= '0;
            holdCnt_q <= 4'd0;
        end else begin
            shCnt_q   <= shCnt_d;
            holdCnt_q <= holdCnt_d;
        end
    end

`ifdef URV_PIPE_PERF_EN
    logic [31:0] perfStall_q;
    logic [31:0] perfFlush_q;
    logic        flushEvent;

    // A trap cancels any simultaneous branch, so a cycle never contributes two flush events.
    assign flushEvent = braAccept | trap_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perfStall_q <= 32'd0;
            perfFlush_q <= 32'd0;
        end else begin
            if (stallVec[0]) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
            if (flushEvent) begin
                perfFlush_q <= perfFlush_q + 32'd1;
            end
        end
    end

    assign perf_stall_o = perfStall_q;
    assign perf_flush_o = perfFlush_q;
`else
    assign perf_stall_o = 32'd0;
    assign perf_flush_o = 32'd0;
`endif

endmodule

// File: doc/urv_pipe_ctrl.md
# urv_pipe_ctrl

Parametrised pipeline control unit for the uRV core, replacing the fixed four-stage stall/kill glue in the CPU top level. From per-stage stall requests, a taken-branch strobe and a trap strobe, it produces per-stage stall and kill vectors for a pipeline of configurable depth and branch-resolve position. It adds a trap flush with a programmable fetch-hold window and optional performance counters. It sits in the CPU top level between the stage modules and owns all pipeline invalidation state.

## Interface
- g_num_stages, 4, pipeline depth N, legal 3..8; stage 0 is fetch, stage N-1 is writeback.
- g_branch_stage, 2, index B of the stage resolving branches; legal 1..N-2.
- g_flush_hold, 2, fetch-hold cycles after a trap; legal 0..15.
- clk_i  in  1  core clock; single clock domain.
- rst_n_i  in  1  reset, asynchronous, active-low.
- stall_req_i  in  N  per-stage stall request; bit i comes from stage i.
- bra_i  in  1  taken branch resolved in stage B this cycle.
- trap_i  in  1  trap/exception taken in stage N-1 this cycle.
- stall_o  out  N  per-stage stall; stage i holds its registers when high.
- kill_o  out  N  per-stage kill; the instruction currently in stage i is invalidated.
- busy_o  out  1  trap hold window active.
- perf_stall_o  out  32  count of cycles with stall_o[0] high (macro-dependent).
- perf_flush_o  out  32  count of accepted branch and trap flush events (macro-dependent).

## Operation
- Stall, combinational:
  - stall_o[i] = OR of stall_req_i[N-1:i] for i < N-1.
  - stall_o[N-1] = 0.
  - stall_o[0] is additionally forced high while busy_o = 1.
- Branch kill:
  - An accepted branch is bra_i & !stall_o[B] & !trap_i.
  - On an accepted branch, kill_o[0..B-1] rise in the same cycle. kill_o[B] stays low, so the branch itself is not killed.
  - The branch also loads shadow counter sh_cnt (width clog2(B+1)) with B.
- Shadow kills:
  - While sh_cnt != 0 and !stall_o[B], sh_cnt decrements once per cycle.
  - During a shadow cycle, kill_o[i] = 1 for every i ≤ B with sh_cnt ≥ B-i+1. This kills the wrong-path instructions still draining into stages 1..B.
  - While stall_o[B] = 1, sh_cnt and the shadow kill pattern are frozen.
  - A new accepted branch during the shadow reloads sh_cnt to B. The kills are the OR of the new-branch kills and the shadow kills.
- Trap:
  - trap_i = 1 forces kill_o to all-ones in that cycle, regardless of stall.
  - sh_cnt clears to 0.
  - hold_cnt loads g_flush_hold.
  - trap_i takes priority over a simultaneous bra_i.
- Hold window:
  - busy_o = (hold_cnt != 0).
  - hold_cnt decrements every cycle; stalls do not affect it.
  - With g_flush_hold = 0, busy_o never rises.
  - A trap during the hold window reloads hold_cnt.
- Reset values:
  - sh_cnt = 0, hold_cnt = 0, busy_o = 0, perf counters = 0.
  - With all inputs low: kill_o = 0 and stall_o = 0.

## Timing
- stall_o and kill_o are combinational from their inputs and registered state. There is zero-cycle latency from stall_req_i, bra_i and trap_i.
- Registered state updates on the rising clk_i edge.
- The shadow lasts exactly B unstalled cycles after the branch cycle. With B = 2:
  - cycle t+1 kills stages 1 and 2;
  - cycle t+2 kills stage 2.
- The hold lasts exactly g_flush_hold cycles after the trap cycle.
- Asserting rst_n_i mid-shadow or mid-hold clears all state immediately; kill_o and busy_o drop without waiting for a clock edge.
- Deasserting rst_n_i is synchronised externally; the block requires no settle cycles.

## Configuration
- URV_PIPE_PERF_EN defined:
  - perf_stall_o increments on every cycle with stall_o[0] = 1.
  - perf_flush_o increments on every accepted branch or trap. A cycle with both counts once.
  - Both counters wrap from 0xFFFF_FFFF to 0.
- URV_PIPE_PERF_EN undefined: both outputs are tied to 0 and no counter flops are synthesised.

## Test plan
- N=4, B=2: single bra_i pulse at cycle t, no stalls -> kill_o = 0011 at t, 0110 at t+1, 0100 at t+2, 0000 at t+3.
- N=4, B=2: bra_i at t, stall_req_i[3] high during t+1..t+2 -> kill_o holds 0110 through t+3 (shadow frozen while stalled), then 0100 at t+4, 0000 at t+5.
- Back-to-back bra_i at t and t+1 -> kill_o = 0011 at t, 0111 at t+1, 0110 at t+2, 0100 at t+3.
- g_flush_hold = 3, trap_i and bra_i together at t -> kill_o = 1111 at t, busy_o and stall_o[0] high t+1..t+3, low at t+4, sh_cnt = 0.
- rst_n_i asserted at t+1 after a trap -> busy_o = 0 and kill_o = 0 immediately; with macro enabled, perf_flush_o reads 0.
- Macro enabled, perf_stall_o preloaded near wrap via 5 stall cycles from 0xFFFF_FFFE -> reads 0x0000_0003.
